// File: rtl/spike_packet_encoder.sv
// Captures a neuron spike vector at each timestep boundary and serialises every
// spiking neuron into a {ts_tag, address} packet queued in a valid/ready FIFO.
//
//  state | meaning
//  IDLE  | waiting for clear; a clear here captures spikes and the timestep tag
//  SCAN  | one snapshot bit per cycle; set bits are pushed, full FIFO stalls
module spike_packet_encoder #(
  parameter int NUM_NEURONS = 8,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   clear,
  input  logic [NUM_NEURONS-1:0] spikes,
  input  logic [11:0]            neuron_base_address,
  output logic [15:0]            packet_data,
  output logic                   packet_valid,
  input  logic                   packet_ready,
  output logic                   busy,
  output logic                   overrun,
  output logic [7:0]             spike_count
);

  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [NUM_NEURONS-1:0] snapshot;
  logic [3:0]             ts_counter;
  logic [3:0]             ts_tag;
  logic [IDX_W-1:0]       idx;

  logic [15:0]            mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       rd_next;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       count_next;
  logic [15:0]            head_next;

  logic        candidate;
  logic        fifo_full;
  logic        capture;
  logic        push;
  logic        pop;
  logic        advance;
  logic [15:0] push_word;

  assign candidate = snapshot[idx];
  assign fifo_full = (count == DEPTH_C);
  assign capture   = (state == IDLE) && clear;
  assign push      = (state == SCAN) && candidate && !fifo_full;
  assign advance   = (state == SCAN) && (!candidate || !fifo_full);
  assign pop       = packet_valid && packet_ready;
  assign push_word = {ts_tag, neuron_base_address + 12'(idx)};
  assign busy      = (state == SCAN);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clear) state_next = SCAN;
      SCAN:    if (advance && (idx == LAST_IDX)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      snapshot    <= '0;
      ts_counter  <= '0;
      ts_tag      <= '0;
      idx         <= '0;
      overrun     <= 1'b0;
      spike_count <= '0;
    end else begin
      if (clear) ts_counter <= ts_counter + 4'd1;
      if (clear && (state == SCAN)) overrun <= 1'b1;
      if (capture) begin
        snapshot    <= spikes;
        ts_tag      <= ts_counter;
        idx         <= '0;
        spike_count <= '0;
      end else begin
        if (advance) idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        if (push && (spike_count != 8'hFF)) spike_count <= spike_count + 8'd1;
      end
    end
  end

  // The head register is loaded with the entry that will be at the head after
  // this cycle's push/pop, so packet_data is a flop output with no read mux.
  always_comb begin
    count_next = count + CNT_W'(push) - CNT_W'(pop);
    rd_next    = pop ? rd_ptr + 1'b1 : rd_ptr;
    if (count_next == '0)
      head_next = '0;
    else if (push && (count_next == CNT_W'(1)))
      head_next = push_word;
    else
      head_next = mem[rd_next];
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      packet_data  <= '0;
      packet_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr       <= rd_next;
      count        <= count_next;
      packet_data  <= head_next;
      packet_valid <= (count_next != '0);
    end
  end

endmodule

// File: tb/tb_spike_packet_encoder.sv
// Bench for spike_packet_encoder: directed scenarios plus randomized captures,
// with a packet-stream scoreboard built from the capture rules.
module tb_spike_packet_encoder;
  localparam int NN = 8;
  localparam int FD = 4;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          clear;
  logic [NN-1:0] spikes;
  logic [11:0]   base;
  logic [15:0]   packet_data;
  logic          packet_valid;
  logic          packet_ready;
  logic          busy;
  logic          overrun;
  logic [7:0]    spike_count;

  spike_packet_encoder #(.NUM_NEURONS(NN), .FIFO_DEPTH(FD)) dut (
    .CLK(CLK), .RESET(RESET), .clear(clear), .spikes(spikes),
    .neuron_base_address(base), .packet_data(packet_data),
    .packet_valid(packet_valid), .packet_ready(packet_ready), .busy(busy),
    .overrun(overrun), .spike_count(spike_count)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [3:0]  ts_model;
  bit          overrun_exp;
  int          exp_cnt;
  logic [15:0] last_pkt;
  bit          rand_ready;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every accepted packet must be the next one the model predicted.
  always @(negedge CLK) begin
    if (RESET === 1'b0 && packet_valid && packet_ready) begin
      check_val("pkt_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check_val("pkt", packet_data, exp_q.pop_front());
      last_pkt = packet_data;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    if (rand_ready) packet_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_clear(input bit expect_idle);
    clear = 1'b1;
    if (expect_idle) begin
      exp_cnt = $countones(spikes);
      for (int i = 0; i < NN; i++)
        if (spikes[i]) exp_q.push_back({ts_model, base + 12'(i)});
    end else begin
      overrun_exp = 1'b1;
    end
    ts_model = ts_model + 4'd1;
    tick();
    clear = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check_val({tag, "_idle_bound"}, 32'(n < 200), 1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    rand_ready = 1'b0;
    packet_ready = 1'b1;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    check_val({tag, "_drain"}, exp_q.size(), 0);
    tick();
    tick();
    check_val({tag, "_empty"}, packet_valid, 0);
  endtask

  initial begin
    RESET = 1'b1; clear = 1'b0; spikes = '0; base = '0;
    packet_ready = 1'b0; rand_ready = 1'b0;
    ts_model = '0; overrun_exp = 1'b0; exp_cnt = 0; last_pkt = '0;
    #3;
    check_val("rst_valid", packet_valid, 0);
    check_val("rst_data", packet_data, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_overrun", overrun, 0);
    check_val("rst_count", spike_count, 0);
    tick();
    tick();
    RESET = 1'b0;

    // basic capture and latency
    base = 12'h100; spikes = 8'b0000_0101; packet_ready = 1'b1;
    tick();
    do_clear(1);
    tick();
    @(negedge CLK);
    check_val("basic_valid0", packet_valid, 1);
    check_val("basic_pkt0", packet_data, 16'h0100);
    tick();
    tick();
    @(negedge CLK);
    check_val("basic_valid1", packet_valid, 1);
    check_val("basic_pkt1", packet_data, 16'h0102);
    repeat (4) tick();
    check_val("basic_busy_last", busy, 1);
    tick();
    check_val("basic_busy_done", busy, 0);
    check_val("basic_count", spike_count, 2);
    drain("basic");

    // backpressure stall
    packet_ready = 1'b0; spikes = 8'hFF;
    tick();
    do_clear(1);
    repeat (11) tick();
    check_val("bp_busy", busy, 1);
    check_val("bp_valid", packet_valid, 1);
    check_val("bp_count", spike_count, 4);
    check_val("bp_head", packet_data, exp_q[0]);
    packet_ready = 1'b1;
    wait_idle("bp");
    drain("bp");
    check_val("bp_count_final", spike_count, 8);

    // timestep tag wrap from a fresh reset
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    exp_q.delete(); ts_model = '0; overrun_exp = 1'b0;
    spikes = 8'h01; base = 12'h100; packet_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      do_clear(1);
      repeat (10) tick();
    end
    drain("tag");
    check_val("tag_wrap_pkt", last_pkt, 16'h0100);

    // overrun
    spikes = 8'h12;
    do_clear(1);
    check_val("ovr_before", overrun, 0);
    tick();
    tick();
    spikes = 8'h81;
    do_clear(0);
    check_val("ovr_set", overrun, 1);
    wait_idle("ovr");
    drain("ovr");
    spikes = 8'h04;
    do_clear(1);
    wait_idle("ovr2");
    drain("ovr2");
    check_val("ovr_sticky", overrun, 1);

    // address wrap
    base = 12'hFFE; spikes = 8'b0000_1111;
    do_clear(1);
    wait_idle("wrap");
    drain("wrap");
    check_val("wrap_count", spike_count, 4);

    // randomized captures with random backpressure
    rand_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      spikes = NN'($urandom);
      base = 12'($urandom);
      tick();
      do_clear(1);
      wait_idle("rand");
      check_val("rand_count", spike_count, exp_cnt);
    end
    drain("rand");
    check_val("rand_overrun", overrun, overrun_exp);

    // asynchronous reset in the middle of a scan
    packet_ready = 1'b0; spikes = 8'hFF; base = 12'h100;
    tick();
    do_clear(1);
    repeat (3) tick();
    check_val("arst_pre_count", spike_count, 3);
    check_val("arst_pre_valid", packet_valid, 1);
    check_val("arst_pre_busy", busy, 1);
    #2;
    RESET = 1'b1;
    #1;
    check_val("arst_valid", packet_valid, 0);
    check_val("arst_busy", busy, 0);
    check_val("arst_count", spike_count, 0);
    check_val("arst_data", packet_data, 0);
    exp_q.delete(); ts_model = '0; overrun_exp = 1'b0;
    #3;
    RESET = 1'b0;
    packet_ready = 1'b1;
    repeat (3) tick();
    check_val("arst_empty", packet_valid, 0);
    check_val("arst_overrun", overrun, 0);
    spikes = 8'h03;
    do_clear(1);
    wait_idle("arst");
    drain("arst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
